// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce
//  Description : Push-button front end. Normalises raw pins to active-high,
//                synchronises them into clk with a two-flop chain, then
//                filters each bit with a stability counter. Produces the
//                debounced level plus one-cycle press/release strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debounce #(
    parameter int unsigned WIDTH           = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] btn_level,
    output logic [WIDTH-1:0] btn_press,
    output logic [WIDTH-1:0] btn_release
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1; keep at least one bit.
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Internally 1 always means "pressed".
    logic [WIDTH-1:0] norm_w;

    logic [WIDTH-1:0]            s1_q, s1_d;
    logic [WIDTH-1:0]            s2_q, s2_d;
    logic [WIDTH-1:0]            stable_q, stable_d;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]            press_q, press_d;
    logic [WIDTH-1:0]            release_q, release_d;

    assign norm_w = ACTIVE_LOW ? ~btn_raw : btn_raw;

    // Next-state: two-stage synchroniser and independent per-bit filters.
    always_comb begin
        s1_d      = norm_w;
        s2_d      = s1_q;
        stable_d  = stable_q;
        cnt_d     = cnt_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (s2_q[i] == stable_q[i]) begin
                // Any agreeing cycle throws away a partial count.
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                // Input disagreed for DEBOUNCE_CYCLES cycles in a row: accept.
                stable_d[i]  = s2_q[i];
                cnt_d[i]     = '0;
                press_d[i]   = s2_q[i];
                release_d[i] = ~s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // State register with synchronous active-low clear to the released state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            stable_q  <= '0;
            cnt_q     <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level   = stable_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule
`default_nettype wire
